// File: rtl/uart_fifo_pkg.sv
// Shared constants and width helpers for the UART receive stream FIFO.
// The optional errored-beat drop feature is enabled by defining UART_RX_FIFO_ERR_DROP_EN.
package uart_fifo_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 16;
  localparam int unsigned ERR_CNT_W  = 8;

  // Pointer width for a power-of-two depth; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Level counter width: it must represent 0 through depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write port, asynchronous read port.
// Used as the FWFT backing store of uart_rx_stream_fifo.
module uart_fifo_mem
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [ptr_width(DEPTH)-1:0]    waddr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [ptr_width(DEPTH)-1:0]    raddr,
  output logic [DATA_W-1:0]              rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset; an entry is only read after it has been written,
  // and a reset port would stop the array mapping onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_stream_fifo.sv
// Avalon-ST receive sink feeding a first-word-fall-through FIFO with level and status.
// Define UART_RX_FIFO_ERR_DROP_EN to drop errored beats and count them in err_count.
module uart_rx_stream_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset_n,
  input  logic [DATA_W-1:0]                 rx_sink_data,
  input  logic                              rx_sink_error,
  input  logic                              rx_sink_valid,
  output logic                              rx_sink_ready,
  input  logic                              rd_en,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [level_width(DEPTH)-1:0]     level,
  output logic                              underflow,
  output logic [ERR_CNT_W-1:0]              err_count,
  input  logic                              clr_status
);

  localparam int unsigned PTR_W = ptr_width(DEPTH);
  localparam int unsigned LVL_W = level_width(DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_d;
  logic             accept;
  logic             wr_fire;
  logic             pop;
  logic             uf_set;
  logic             underflow_q;

  assign empty         = (level_q == '0);
  assign full          = (level_q == DEPTH_LVL);
  assign rx_sink_ready = !full;
  assign level         = level_q;
  assign underflow     = underflow_q;

  assign accept = rx_sink_valid && rx_sink_ready;
  assign pop    = rd_en && !empty;
  assign uf_set = rd_en && empty;

`ifdef UART_RX_FIFO_ERR_DROP_EN
  logic                 err_inc;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  // Errored beats are still handshaken so the source never stalls on them.
  assign wr_fire = accept && !rx_sink_error;
  assign err_inc = accept && rx_sink_error;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      err_cnt_q <= '0;
    end else if (clr_status) begin
      err_cnt_q <= '0;
    end else if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_err;

  assign unused_err = rx_sink_error;
  assign wr_fire    = accept;
  assign err_count  = '0;
`endif

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    case ({wr_fire, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level_q <= level_d;
    end
  end

  // Clear wins over a same-cycle underflow so software never loses a clear.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      underflow_q <= 1'b0;
    end else if (clr_status) begin
      underflow_q <= 1'b0;
    end else if (uf_set) begin
      underflow_q <= 1'b1;
    end
  end

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk_clk),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (rx_sink_data),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Ready gating makes these invariants structural; they guard later edits.
  a_no_write_when_full : assert property (
    @(posedge clk_clk) disable iff (!reset_reset_n) wr_fire |-> !full);
  a_level_in_range : assert property (
    @(posedge clk_clk) disable iff (!reset_reset_n) level_q <= DEPTH_LVL);

endmodule

// File: tb/tb_uart_rx_stream_fifo.sv
// Self-checking bench for uart_rx_stream_fifo: queue-based reference model plus directed vectors.
// Honours UART_RX_FIFO_ERR_DROP_EN to pick the expected errored-beat behaviour.
module tb_uart_rx_stream_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int LVL_W  = 5;
`ifdef UART_RX_FIFO_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic              clk_clk;
  logic              reset_reset_n;
  logic [DATA_W-1:0] rx_sink_data;
  logic              rx_sink_error;
  logic              rx_sink_valid;
  logic              rx_sink_ready;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              underflow;
  logic [7:0]        err_count;
  logic              clr_status;

  uart_rx_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .rx_sink_data  (rx_sink_data),
    .rx_sink_error (rx_sink_error),
    .rx_sink_valid (rx_sink_valid),
    .rx_sink_ready (rx_sink_ready),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .empty         (empty),
    .full          (full),
    .level         (level),
    .underflow     (underflow),
    .err_count     (err_count),
    .clr_status    (clr_status)
  );

  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered byte queue plus the two status values.
  byte unsigned mq[$];
  bit           m_uf = 1'b0;
  int           m_ec = 0;

  always @(posedge clk_clk or negedge reset_reset_n) begin
    int sz;
    bit acc;
    if (!reset_reset_n) begin
      mq.delete();
      m_uf = 1'b0;
      m_ec = 0;
    end else begin
      sz  = mq.size();
      acc = rx_sink_valid && (sz < DEPTH);
      if (rd_en) begin
        if (sz > 0) void'(mq.pop_front());
        else m_uf = 1'b1;
      end
      if (acc) begin
        if (DROP && rx_sink_error) begin
          if (m_ec < 255) m_ec++;
        end else begin
          mq.push_back(rx_sink_data);
        end
      end
      if (clr_status) begin
        m_uf = 1'b0;
        m_ec = 0;
      end
    end
  end

  // Every falling edge: all outputs against the model; rd_data only while entries exist.
  always @(negedge clk_clk) begin
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("level", level, mq.size());
    check("ready", rx_sink_ready, mq.size() < DEPTH);
    check("underflow", underflow, m_uf);
    check("err_count", err_count, m_ec);
    if (mq.size() > 0) check("rd_data", rd_data, mq[0]);
  end

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    byte unsigned exp_q[$];
    reset_reset_n = 1'b1;
    rx_sink_data  = '0;
    rx_sink_error = 1'b0;
    rx_sink_valid = 1'b0;
    rd_en         = 1'b0;
    clr_status    = 1'b0;
    #2 reset_reset_n = 1'b0;
    repeat (2) @(posedge clk_clk);
    #1 reset_reset_n = 1'b1;

    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_level", level, 0);
    check("rst_ready", rx_sink_ready, 1);
    check("rst_uf", underflow, 0);
    check("rst_err", err_count, 0);

    // Single beat: visible one edge after acceptance, popped back to empty.
    rx_sink_data  = 8'h5A;
    rx_sink_valid = 1'b1;
    check("t1_empty_pre", empty, 1);
    step();
    rx_sink_valid = 1'b0;
    check("t1_empty", empty, 0);
    check("t1_data", rd_data, 8'h5A);
    check("t1_level", level, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t1_pop_empty", empty, 1);
    check("t1_pop_level", level, 0);

    // Fill to DEPTH, hold a 17th beat, then drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      rx_sink_data  = 8'(i);
      rx_sink_valid = 1'b1;
      step();
    end
    rx_sink_data = 8'h10;
    repeat (3) step();
    check("t2_full", full, 1);
    check("t2_ready", rx_sink_ready, 0);
    check("t2_level", level, 16);
    rx_sink_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("t2_drain", rd_data, i);
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    check("t2_empty", empty, 1);

    // Sustained push+pop for 100 cycles wraps both pointers several times.
    rx_sink_data  = 8'h00;
    rx_sink_valid = 1'b1;
    step();
    for (int k = 0; k < 100; k++) begin
      rx_sink_data = 8'(k + 1);
      rd_en        = 1'b1;
      check("t3_head", rd_data, k & 255);
      step();
      check("t3_level", level, 1);
    end
    rx_sink_valid = 1'b0;
    check("t3_last", rd_data, 100);
    step();
    rd_en = 1'b0;
    check("t3_empty", empty, 1);

    // Underflow: sticky, pointers untouched, cleared by clr_status even on a same-cycle set.
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t4_uf_set", underflow, 1);
    repeat (3) step();
    check("t4_uf_sticky", underflow, 1);
    rx_sink_data  = 8'h77;
    rx_sink_valid = 1'b1;
    step();
    rx_sink_valid = 1'b0;
    check("t4_level", level, 1);
    check("t4_data", rd_data, 8'h77);
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("t4_uf_clr", underflow, 0);
    rd_en = 1'b1;
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    rd_en      = 1'b0;
    check("t4_clr_prio", underflow, 0);
    check("t4_empty", empty, 1);

    // Errored middle beat: dropped and counted, or stored, depending on the build.
    rx_sink_valid = 1'b1;
    rx_sink_data  = 8'h11; rx_sink_error = 1'b0; step();
    rx_sink_data  = 8'h22; rx_sink_error = 1'b1; step();
    rx_sink_data  = 8'h33; rx_sink_error = 1'b0; step();
    rx_sink_valid = 1'b0;
    if (DROP) exp_q = '{8'h11, 8'h33};
    else      exp_q = '{8'h11, 8'h22, 8'h33};
    check("t5_level", level, exp_q.size());
    check("t5_err", err_count, DROP ? 1 : 0);
    foreach (exp_q[i]) begin
      check("t5_drain", rd_data, exp_q[i]);
      rd_en = 1'b1;
      step();
    end
    rd_en      = 1'b0;
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    check("t5_err_clr", err_count, 0);

    // Asynchronous reset mid-burst at level 7, then a fresh beat reads back first.
    for (int i = 0; i < 7; i++) begin
      rx_sink_data  = 8'(8'h40 + i);
      rx_sink_valid = 1'b1;
      step();
    end
    check("t6_level7", level, 7);
    #2 reset_reset_n = 1'b0;
    #1;
    check("t6_rst_empty", empty, 1);
    check("t6_rst_level", level, 0);
    check("t6_rst_ready", rx_sink_ready, 1);
    check("t6_rst_full", full, 0);
    step();
    rx_sink_valid = 1'b0;
    reset_reset_n = 1'b1;
    rx_sink_data  = 8'hA5;
    rx_sink_valid = 1'b1;
    step();
    rx_sink_valid = 1'b0;
    check("t6_data", rd_data, 8'hA5);
    check("t6_level", level, 1);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    check("t6_empty", empty, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_stream_fifo.md
# uart_rx_stream_fifo

Receive-side consumer for the RS232 UART core's Avalon-ST receive source. Accepts bytes with ready/valid backpressure and buffers them in a first-word-fall-through FIFO for user logic. Reports fill level, a sticky underflow flag, and optionally handles errored beats. Sits between the UART core's receive source and the user command/data path.

## Interface
Parameters:
- DATA_W, 8, byte width; must match the UART core data width.
- DEPTH, 16, FIFO entries; power of two, 4 to 256.

Ports:
- clk_clk  in  1  single system clock; all logic on the rising edge.
- reset_reset_n  in  1  asynchronous assert, active-low reset.
- rx_sink_data  in  DATA_W  received byte from the UART receive source.
- rx_sink_error  in  1  framing/parity error qualifier for the beat.
- rx_sink_valid  in  1  beat valid.
- rx_sink_ready  out  1  beat accepted when valid and ready are both high.
- rd_en  in  1  pop the head entry.
- rd_data  out  DATA_W  head entry; meaningful only while empty is low.
- empty  out  1  FIFO holds no entries.
- full  out  1  FIFO holds DEPTH entries.
- level  out  $clog2(DEPTH+1)  current entry count, 0 to DEPTH.
- underflow  out  1  sticky; set by rd_en while empty.
- err_count  out  8  saturating count of dropped errored beats.
- clr_status  in  1  synchronous clear of underflow and err_count.

## Operation
- Avalon-ST sink, readyLatency 0. rx_sink_ready = !full, driven combinationally from registered state. A beat is accepted iff rx_sink_valid && rx_sink_ready.
- Push: accepted byte is written at wr_ptr, wr_ptr increments modulo DEPTH, level increments.
- Pop: rd_en && !empty advances rd_ptr modulo DEPTH and decrements level. rd_en while empty: no pointer change; underflow set.
- Simultaneous push and pop (not full, not empty): both pointers advance, level unchanged, data integrity preserved.
- When full: ready is low, so the FIFO cannot overflow. Push and pop in the same cycle cannot occur when full, because ready is already low.
- Pointers are log2(DEPTH) bits wide and wrap naturally. full and empty derive from level.
- clr_status has priority over a same-cycle underflow set and err_count increment; the result is 0.
- Reset (asynchronous, any time, including mid-burst): pointers and level go to 0. empty=1, full=0, rx_sink_ready=1, underflow=0, err_count=0. rd_data is undefined while empty. Storage contents are not reset.

## Timing
- Write-to-read latency is 1 cycle. A byte accepted at edge N makes empty=0 and rd_data valid after edge N.
- rd_data is first-word-fall-through: it shows the head entry combinationally from storage at rd_ptr. It updates the cycle after a pop.
- level, full, empty and rx_sink_ready update on the edge following the push or pop.
- Throughput is one push and one pop per cycle sustained.

## Configuration
- UART_RX_FIFO_ERR_DROP_EN defined:
  - A beat with rx_sink_error=1 is still accepted, so ready behaviour is unchanged.
  - The beat is not written to the FIFO.
  - err_count increments, saturating at 255.
- Undefined:
  - Errored beats are stored like normal bytes; the error bit is discarded.
  - err_count is tied to 0.

## Structure
- Package uart_fifo_pkg holds DATA_W_DEF and DEPTH_DEF, the ERR_CNT_W=8 constant, and the pointer/level width helper function.
- One sub-module, uart_fifo_mem: simple dual-port storage with a synchronous write port and an asynchronous read port, parameterised on DATA_W and DEPTH.
- Top level holds pointers, level counter, status flags and handshake logic.

## Test plan
- Reset then single beat 0x5A -> empty falls one cycle after acceptance; rd_data=0x5A; rd_en returns empty=1 and level=0.
- Push 16 beats 0x00..0x0F with DEPTH=16 and no reads -> full=1, rx_sink_ready=0, a held 17th beat is not accepted; drain yields 0x00..0x0F in order.
- Continuous push and pop for 100 cycles with incrementing data -> level constant, no loss, pointer wrap verified.
- rd_en while empty -> underflow=1 and sticky; clr_status -> 0; pointers unchanged.
- With UART_RX_FIFO_ERR_DROP_EN, send 0x11, 0x22 with error=1, then 0x33 -> FIFO yields 0x11 then 0x33; err_count=1. Without the macro, the FIFO yields 0x11, 0x22, 0x33 and err_count stays 0.
- Assert reset_reset_n low mid-burst at level=7 -> immediate empty=1, level=0, rx_sink_ready=1; a new beat 0xA5 after release is read back first.
